// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage: default widths, opcode map,
// condition-code encodings and the component-move sequencer states.
package writeback_stage_pkg;

  localparam int WB_REG_WIDTH     = 16;
  localparam int WB_VREG_WIDTH    = 64;
  localparam int WB_VREG_ID_WIDTH = 6;
  localparam int WB_PC_WIDTH      = 16;
  localparam int WB_OPCODE_WIDTH  = 8;
  localparam int WB_NUM_COMP      = 4;

  localparam logic [7:0] OP_ADD_D     = 8'h01;
  localparam logic [7:0] OP_ADD_F     = 8'h02;
  localparam logic [7:0] OP_ADDI_D    = 8'h03;
  localparam logic [7:0] OP_ADDI_F    = 8'h04;
  localparam logic [7:0] OP_AND_D     = 8'h05;
  localparam logic [7:0] OP_ANDI_D    = 8'h06;
  localparam logic [7:0] OP_MOV       = 8'h07;
  localparam logic [7:0] OP_MOVI_D    = 8'h08;
  localparam logic [7:0] OP_MOVI_F    = 8'h09;
  localparam logic [7:0] OP_LDB       = 8'h10;
  localparam logic [7:0] OP_LDW       = 8'h11;
  localparam logic [7:0] OP_STB       = 8'h12;
  localparam logic [7:0] OP_STW       = 8'h13;
  localparam logic [7:0] OP_CMP       = 8'h20;
  localparam logic [7:0] OP_CMPI      = 8'h21;
  localparam logic [7:0] OP_BRN       = 8'h30;
  localparam logic [7:0] OP_BRZ       = 8'h31;
  localparam logic [7:0] OP_BRP       = 8'h32;
  localparam logic [7:0] OP_BRNZ      = 8'h33;
  localparam logic [7:0] OP_BRNP      = 8'h34;
  localparam logic [7:0] OP_BRZP      = 8'h35;
  localparam logic [7:0] OP_BRNZP     = 8'h36;
  localparam logic [7:0] OP_JMP       = 8'h37;
  localparam logic [7:0] OP_JSR       = 8'h38;
  localparam logic [7:0] OP_JSRR      = 8'h39;
  localparam logic [7:0] OP_VADD      = 8'h40;
  localparam logic [7:0] OP_VMOV      = 8'h41;
  localparam logic [7:0] OP_VMOVI     = 8'h42;
  localparam logic [7:0] OP_VCOMPMOV  = 8'h43;
  localparam logic [7:0] OP_VCOMPMOVI = 8'h44;

  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

  // JSR/JSRR link register
  localparam logic [3:0] LINK_REG = 4'd7;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_VREAD = 2'd1,
    WB_VWAIT = 2'd2
  } wb_state_e;

  function automatic logic is_comp_move(input logic [7:0] op);
    return (op == OP_VCOMPMOV) || (op == OP_VCOMPMOVI);
  endfunction

endpackage

// File: rtl/writeback_stage_cc_gen.sv
// Combinational condition-code generator: one-hot {N,Z,P} from a scalar result.
module cc_gen
  import writeback_stage_pkg::*;
#(
  parameter int W = WB_REG_WIDTH
) (
  input  logic [W-1:0] data_i,
  output logic [2:0]   cc_o
);

  always_comb begin
    cc_o = CC_P;
    if (data_i[W-1]) begin
      cc_o = CC_N;
    end else if (data_i == '0) begin
      cc_o = CC_Z;
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Commit stage: scalar/vector RF writes, CC updates, PC redirects, retire count.
// Single-cycle ops commit one edge after acceptance; component moves take 3 edges.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int REG_WIDTH     = WB_REG_WIDTH,
  parameter int VREG_WIDTH    = WB_VREG_WIDTH,
  parameter int VREG_ID_WIDTH = WB_VREG_ID_WIDTH,
  parameter int PC_WIDTH      = WB_PC_WIDTH,
  parameter int OPCODE_WIDTH  = WB_OPCODE_WIDTH
) (
  input  logic                     I_CLOCK,
  input  logic                     I_RESET,
  input  logic                     I_LOCK,
  input  logic                     I_MW_Valid,
  input  logic [PC_WIDTH-1:0]      I_PC,
  input  logic [OPCODE_WIDTH-1:0]  I_Opcode,
  input  logic [3:0]               I_DestRegIdx,
  input  logic [VREG_ID_WIDTH-1:0] I_DestVRegIdx,
  input  logic [1:0]               I_Idx,
  input  logic [REG_WIDTH-1:0]     I_ALUOut,
  input  logic [REG_WIDTH-1:0]     I_MemOut,
  input  logic [VREG_WIDTH-1:0]    I_VecResult,
  input  logic                     I_BranchTaken,
  input  logic [PC_WIDTH-1:0]      I_BranchPC,
  input  logic [VREG_WIDTH-1:0]    I_VRdData,
  output logic                     O_WBStall,
  output logic                     O_VRdReq,
  output logic [VREG_ID_WIDTH-1:0] O_VRdIdx,
  output logic                     O_RegWEn,
  output logic [3:0]               O_WriteBackRegIdx,
  output logic [REG_WIDTH-1:0]     O_WriteBackData,
  output logic                     O_VRegWEn,
  output logic [VREG_ID_WIDTH-1:0] O_WriteBackVRegIdx,
  output logic [VREG_WIDTH-1:0]    O_WriteBackVData,
  output logic                     O_CCWEn,
  output logic [2:0]               O_CCValue,
  output logic                     O_WriteBackPCEn,
  output logic [PC_WIDTH-1:0]      O_WriteBackPC,
  output logic [3:0]               O_WDDestRegIdx,
  output logic                     O_WDDestWrite,
  output logic [31:0]              O_RetireCount
);

  wb_state_e state_q, state_d;

  logic                     reg_wen_q;
  logic [3:0]               reg_idx_q;
  logic [REG_WIDTH-1:0]     reg_data_q;
  logic                     vreg_wen_q;
  logic [VREG_ID_WIDTH-1:0] vreg_idx_q;
  logic [VREG_WIDTH-1:0]    vreg_data_q;
  logic                     cc_wen_q;
  logic [2:0]               cc_q;
  logic                     pc_en_q;
  logic [PC_WIDTH-1:0]      pc_q;
  logic [31:0]              retire_q, retire_d;

  // Operands of an in-flight component move
  logic [VREG_ID_WIDTH-1:0] cm_vidx_q;
  logic [1:0]               cm_comp_q;
  logic [REG_WIDTH-1:0]     cm_data_q;

  logic [7:0]               op;
  logic                     accept;
  logic                     cm_commit;
  logic                     dec_reg_we;
  logic                     dec_cc_we;
  logic                     dec_vreg_we;
  logic                     dec_pc_en;
  logic                     dec_cmov;
  logic [3:0]               dec_reg_idx;
  logic [REG_WIDTH-1:0]     dec_data;
  logic [2:0]               dec_cc;
  logic [VREG_WIDTH-1:0]    merged_vec;

  assign op        = 8'(I_Opcode);
  assign O_WBStall = (state_q != WB_IDLE);
  assign accept    = I_LOCK && I_MW_Valid && (state_q == WB_IDLE);
  assign cm_commit = I_LOCK && (state_q == WB_VWAIT);

  always_comb begin
    dec_reg_we  = 1'b0;
    dec_cc_we   = 1'b0;
    dec_vreg_we = 1'b0;
    dec_pc_en   = 1'b0;
    dec_cmov    = 1'b0;
    dec_reg_idx = I_DestRegIdx;
    dec_data    = I_ALUOut;
    case (op)
      OP_ADD_D, OP_ADD_F, OP_ADDI_D, OP_ADDI_F, OP_AND_D, OP_ANDI_D,
      OP_MOV, OP_MOVI_D, OP_MOVI_F: begin
        dec_reg_we = 1'b1;
        dec_cc_we  = 1'b1;
      end
      OP_LDW: begin
        dec_data   = I_MemOut;
        dec_reg_we = 1'b1;
        dec_cc_we  = 1'b1;
      end
      OP_LDB: begin
        dec_data   = {{(REG_WIDTH-8){I_MemOut[7]}}, I_MemOut[7:0]};
        dec_reg_we = 1'b1;
        dec_cc_we  = 1'b1;
      end
      OP_CMP, OP_CMPI: begin
        dec_cc_we = 1'b1;
      end
      OP_BRN, OP_BRZ, OP_BRP, OP_BRNZ, OP_BRNP, OP_BRZP, OP_BRNZP: begin
        dec_pc_en = I_BranchTaken;
      end
      OP_JMP: begin
        dec_pc_en = 1'b1;
      end
      OP_JSR, OP_JSRR: begin
        dec_reg_we  = 1'b1;
        dec_reg_idx = LINK_REG;
        dec_data    = REG_WIDTH'(I_PC);
        dec_pc_en   = 1'b1;
      end
      OP_VADD, OP_VMOV, OP_VMOVI: begin
        dec_vreg_we = 1'b1;
      end
      OP_VCOMPMOV, OP_VCOMPMOVI: begin
        dec_cmov = 1'b1;
      end
      default: begin
        // Stores and unknown opcodes retire without side effects
      end
    endcase
  end

  cc_gen #(
    .W(REG_WIDTH)
  ) u_cc_gen (
    .data_i(dec_data),
    .cc_o  (dec_cc)
  );

  always_comb begin
    merged_vec = I_VRdData;
    for (int k = 0; k < WB_NUM_COMP; k++) begin
      if (cm_comp_q == 2'(k)) begin
        merged_vec[k*REG_WIDTH +: REG_WIDTH] = cm_data_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_IDLE: begin
        if (accept && is_comp_move(op)) begin
          state_d = WB_VREAD;
        end
      end
      WB_VREAD: begin
        if (I_LOCK) begin
          state_d = WB_VWAIT;
        end
      end
      WB_VWAIT: begin
        // Read data is only guaranteed the cycle after the request, so a
        // freeze here falls back to re-issuing the read.
        state_d = I_LOCK ? WB_IDLE : WB_VREAD;
      end
      default: begin
        state_d = WB_IDLE;
      end
    endcase
  end

  always_comb begin
    retire_d = retire_q;
    if ((accept && !dec_cmov) || cm_commit) begin
      retire_d = retire_q + 32'd1;
    end
  end

  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      state_q     <= WB_IDLE;
      reg_wen_q   <= 1'b0;
      reg_idx_q   <= '0;
      reg_data_q  <= '0;
      vreg_wen_q  <= 1'b0;
      vreg_idx_q  <= '0;
      vreg_data_q <= '0;
      cc_wen_q    <= 1'b0;
      cc_q        <= '0;
      pc_en_q     <= 1'b0;
      pc_q        <= '0;
      retire_q    <= '0;
      cm_vidx_q   <= '0;
      cm_comp_q   <= '0;
      cm_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      retire_q   <= retire_d;
      reg_wen_q  <= 1'b0;
      vreg_wen_q <= 1'b0;
      cc_wen_q   <= 1'b0;
      pc_en_q    <= 1'b0;
      if (accept) begin
        if (dec_reg_we) begin
          reg_wen_q  <= 1'b1;
          reg_idx_q  <= dec_reg_idx;
          reg_data_q <= dec_data;
        end
        if (dec_cc_we) begin
          cc_wen_q <= 1'b1;
          cc_q     <= dec_cc;
        end
        if (dec_vreg_we) begin
          vreg_wen_q  <= 1'b1;
          vreg_idx_q  <= I_DestVRegIdx;
          vreg_data_q <= I_VecResult;
        end
        if (dec_pc_en) begin
          pc_en_q <= 1'b1;
          pc_q    <= I_BranchPC;
        end
        if (dec_cmov) begin
          cm_vidx_q <= I_DestVRegIdx;
          cm_comp_q <= I_Idx;
          cm_data_q <= I_ALUOut;
        end
      end
      if (cm_commit) begin
        vreg_wen_q  <= 1'b1;
        vreg_idx_q  <= cm_vidx_q;
        vreg_data_q <= merged_vec;
      end
    end
  end

  assign O_VRdReq           = (state_q == WB_VREAD);
  assign O_VRdIdx           = cm_vidx_q;
  assign O_RegWEn           = reg_wen_q;
  assign O_WriteBackRegIdx  = reg_idx_q;
  assign O_WriteBackData    = reg_data_q;
  assign O_VRegWEn          = vreg_wen_q;
  assign O_WriteBackVRegIdx = vreg_idx_q;
  assign O_WriteBackVData   = vreg_data_q;
  assign O_CCWEn            = cc_wen_q;
  assign O_CCValue          = cc_q;
  assign O_WriteBackPCEn    = pc_en_q;
  assign O_WriteBackPC      = pc_q;
  assign O_WDDestRegIdx     = reg_idx_q;
  assign O_WDDestWrite      = reg_wen_q;
  assign O_RetireCount      = retire_q;

endmodule
